// File: rtl/button_pkg.sv
// Shared types and helpers for the button event decoder.
package button_pkg;

    // Decoder states: idle, button down (short so far), long hold, double-click window.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2,
        GAP  = 2'd3
    } btn_state_e;

    // Largest of three timer lengths; sizes the single shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third history flop for edge detection.
// Usable for any slow asynchronous board input.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Shift the input through the synchronizer and history stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer flops; history resets low so a held input still yields a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/button_event.sv
// Button gesture decoder: press/release, long press with auto-repeat,
// and double-click detection from a debounced asynchronous button level.
//
// state | meaning
// IDLE  | button up, no double-click window open
// DOWN  | button down, not yet long; cnt measures hold time
// LONG  | long press reached; cnt paces repeat pulses
// GAP   | button up after a short press; cnt measures double-click window
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DBL_CYCLES    = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic dbl_o
);

    localparam int CNT_MAX = max3(LONG_CYCLES, REPEAT_CYCLES, DBL_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Timer lengths below two leave no room for the terminal-count compare.
    generate
        if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 || DBL_CYCLES < 2) begin : g_bad_param
            $error("button_event: LONG_CYCLES, REPEAT_CYCLES and DBL_CYCLES must all be >= 2");
        end
    endgenerate

    logic level;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign held_o = level;

    btn_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             second_q,  second_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             long_q,    long_d;
    logic             repeat_q,  repeat_d;
    logic             dbl_q,     dbl_d;

    // Next-state and event decode. Edges take priority over terminal counts:
    // a fall beats long/repeat, a rise on the last window cycle is a double-click.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        second_d  = second_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        dbl_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    press_d  = 1'b1;
                    second_d = 1'b0;
                    state_d  = DOWN;
                end
            end

            DOWN: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    // The second click of a double-click does not open a new window.
                    state_d   = second_q ? IDLE : GAP;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == REP_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            GAP: begin
                if (rise) begin
                    press_d  = 1'b1;
                    dbl_d    = 1'b1;
                    second_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = DOWN;
                end else if (cnt_q == DBL_TC) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            second_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            second_q  <= second_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            dbl_q     <= dbl_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign dbl_o     = dbl_q;

endmodule
